// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared state encoding, default geometry and address helper
package store_buffer_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DUMP = 2'd2} state_t;
  function automatic logic [AW_DEF-3:0] word_idx(input logic [AW_DEF-1:0] addr);
    return addr[AW_DEF-1:2];
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline store/load handshake plus MainMemory port bundle
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic st_ready;
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic ld_fwd;
  logic halt_req;
  logic mem_write_en;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic mem_read_en;
  logic [AW-1:0] mem_read_address;
  logic [DW-1:0] mem_read_data;
  logic show_en;
  modport master (
    output st_valid, st_addr, st_data, ld_en, ld_addr, halt_req, mem_read_data,
    input  st_ready, ld_data, ld_fwd, mem_write_en, mem_write_address, mem_write_data,
           mem_read_en, mem_read_address, show_en
  );
  modport slave (
    input  st_valid, st_addr, st_data, ld_en, ld_addr, halt_req, mem_read_data,
    output st_ready, ld_data, ld_fwd, mem_write_en, mem_write_address, mem_write_data,
           mem_read_en, mem_read_address, show_en
  );
endinterface

// File: rtl/store_buffer_forward_match.sv
// sb_forward_match: youngest valid entry whose word index equals the load word
module sb_forward_match #(
  parameter int DEPTH = 4,
  parameter int WW = 30
) (
  input  logic [WW-1:0] words [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [WW-1:0] ld_word,
  output logic hit,
  output logic [$clog2(DEPTH)-1:0] index
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // walk oldest to youngest from head so the last match found is the youngest
  always_comb begin
    hit = 1'b0;
    index = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && words[idx] == ld_word) begin
        hit = 1'b1;
        index = idx;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO with load forwarding and halt/drain/dump sequencing
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic clk,
  input logic rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-3:0] e_word [DEPTH];
  logic [DW-1:0] e_data [DEPTH];
  logic [DEPTH-1:0] valid, set_m, clr_m;
  logic [PW-1:0] head, tail, hit_idx;
  logic [CW-1:0] count;
  state_t state, state_d;
  logic show, full, empty, push, pop, hit;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign bus.st_ready = ~full & (state == RUN);
  assign push = bus.st_valid & bus.st_ready;
  assign pop = ~empty & (state != DUMP);
  assign set_m = push ? DEPTH'(1) << tail : '0;
  assign clr_m = pop ? DEPTH'(1) << head : '0;
  assign bus.mem_write_en = pop;
  assign bus.mem_write_address = {e_word[head], 2'b00};
  assign bus.mem_write_data = e_data[head];
  assign bus.show_en = show;
  assign bus.ld_fwd = bus.ld_en & hit;
  assign bus.ld_data = bus.ld_fwd ? e_data[hit_idx] : bus.mem_read_data;
  assign bus.mem_read_en = bus.ld_en & ~hit;
  assign bus.mem_read_address = bus.ld_addr;
  sb_forward_match #(.DEPTH(DEPTH), .WW(AW-2)) u_match (
    .words(e_word),
    .valid(valid),
    .head(head),
    .ld_word(bus.ld_addr[AW-1:2]),
    .hit(hit),
    .index(hit_idx)
  );
  // halt moves to drain; drain finishes into the terminal dump state once empty
  always_comb begin
    state_d = (state == RUN && bus.halt_req) ? DRAIN :
              (state == DRAIN && empty) ? DUMP : state;
  end
  // pointers, occupancy, valid bits and FSM; reset drops any pending stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      state <= RUN;
      show <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      valid <= (valid & ~clr_m) | set_m;
      state <= state_d;
      show <= state == DUMP;
    end
  end
  // entry payload needs no reset; valid bits qualify it
  always_ff @(posedge clk) begin
    if (push) begin
      e_word[tail] <= bus.st_addr[AW-1:2];
      e_data[tail] <= bus.st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: random and directed stimulus against a queue-based reference model
module tb_store_buffer;
  import store_buffer_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  store_buffer_if #(.AW(32), .DW(32)) bus ();
  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  logic [31:0] ram [64] = '{default: 32'h0};
  logic [31:0] exp_ram [64] = '{default: 32'h0};
  assign bus.mem_read_data = ram[bus.mem_read_address[7:2]];
  always @(posedge clk) if (bus.mem_write_en) ram[bus.mem_write_address[7:2]] <= bus.mem_write_data;
  ent_t q[$];
  int mode = 0;
  logic show_m = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
  endfunction
  task automatic tick();
    logic [29:0] lw;
    int fi;
    bit wen, rdy, pre_empty;
    @(negedge clk);
    wen = q.size() > 0 && mode != 2;
    rdy = q.size() < DEPTH && mode == 0;
    chk("mem_write_en", bus.mem_write_en, wen);
    if (wen) begin
      chk("mem_write_address", bus.mem_write_address, {q[0].word, 2'b00});
      chk("mem_write_data", bus.mem_write_data, q[0].data);
    end
    chk("st_ready", bus.st_ready, rdy);
    chk("show_en", bus.show_en, show_m);
    lw = word_idx(bus.ld_addr);
    fi = -1;
    foreach (q[i]) if (q[i].word == lw) fi = i;
    if (bus.ld_en) begin
      chk("ld_fwd", bus.ld_fwd, fi >= 0);
      chk("ld_data", bus.ld_data, fi >= 0 ? q[fi].data : exp_ram[lw[5:0]]);
      chk("mem_read_en", bus.mem_read_en, fi < 0);
    end else begin
      chk("ld_fwd_idle", bus.ld_fwd, 1'b0);
      chk("mem_read_en_idle", bus.mem_read_en, 1'b0);
    end
    pre_empty = q.size() == 0;
    show_m = mode == 2;
    if (wen) begin
      exp_ram[q[0].word[5:0]] = q[0].data;
      void'(q.pop_front());
    end
    if (bus.st_valid && rdy) q.push_back('{word_idx(bus.st_addr), bus.st_data});
    if (mode == 0 && bus.halt_req) mode = 1;
    else if (mode == 1 && pre_empty) mode = 2;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mem_write_en", bus.mem_write_en, 1'b0);
    chk("rst_show_en", bus.show_en, 1'b0);
    chk("rst_st_ready", bus.st_ready, 1'b1);
    chk("rst_ld_fwd", bus.ld_fwd, 1'b0);
    q.delete();
    mode = 0;
    show_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr = a;
    bus.st_data = d;
  endtask
  task automatic rand_cycles(input int n, input int pst);
    for (int i = 0; i < n; i++) begin
      bus.st_valid = $urandom_range(0, 99) < pst;
      bus.st_addr = rand_addr();
      bus.st_data = $urandom();
      bus.ld_en = 1'($urandom_range(0, 1));
      bus.ld_addr = rand_addr();
      bus.halt_req = 1'b0;
      tick();
    end
  endtask
  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr = '0;
    bus.st_data = '0;
    bus.ld_en = 1'b0;
    bus.ld_addr = '0;
    bus.halt_req = 1'b0;
    #1;
    do_reset();
    store(32'h10, 32'hAAAA_0001);
    tick();
    bus.st_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      store(32'h40 + 32'(i * 4), 32'h100 + 32'(i));
      tick();
    end
    bus.st_valid = 1'b0;
    tick();
    store(32'h20, 32'h1);
    tick();
    store(32'h20, 32'h2);
    bus.ld_en = 1'b1;
    bus.ld_addr = 32'h20;
    tick();
    bus.st_valid = 1'b0;
    tick();
    bus.ld_addr = 32'h24;
    tick();
    store(32'h20, 32'h3);
    bus.ld_en = 1'b0;
    tick();
    bus.st_valid = 1'b0;
    bus.ld_en = 1'b1;
    bus.ld_addr = 32'h23;
    tick();
    rand_cycles(400, 60);
    store(32'h34, 32'h77);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    rand_cycles(12, 70);
    do_reset();
    rand_cycles(50, 50);
    bus.ld_en = 1'b0;
    store(32'h30, 32'h55);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    bus.st_valid = 1'b0;
    bus.ld_en = 1'b1;
    bus.ld_addr = 32'h30;
    do_reset();
    bus.ld_en = 1'b0;
    tick();
    tick();
    rand_cycles(200, 60);
    bus.st_valid = 1'b0;
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    rand_cycles(8, 0);
    for (int i = 0; i < 64; i++) chk("ram_word", ram[i], exp_ram[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
